// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register-dump block: default register file
// geometry and the dump controller state encoding.
package cpu_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 6;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_reg_dump.sv
// Counts CPU run cycles until halt (or timeout), then snapshots the register
// file and streams {cycle_count, r0 .. r(N-1)} over a valid/ready port.
module cpu_reg_dump #(
  parameter int MAX_CLOCKS = 100000,
  parameter int XLEN       = cpu_pkg::XLEN,
  parameter int NUM_REGS   = cpu_pkg::NUM_REGS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] registers [0:NUM_REGS-1],
  input  logic            completed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [5:0]      out_index,
  output logic            out_last,
  output logic [31:0]     cycle_count,
  output logic            timed_out,
  output logic            dump_done
);
  import cpu_pkg::*;

  // Snapshot address width; the word index is one wider in range (0..NUM_REGS).
  localparam int          SNAP_AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] TIMEOUT_AT = 32'(MAX_CLOCKS - 1);
  localparam logic [5:0]  LAST_IDX   = 6'(NUM_REGS);

  state_e            state_q, state_d;
  logic [5:0]        index_q, index_d;
  logic [31:0]       cycle_count_q, cycle_count_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              timed_out_q, timed_out_d;
  logic              dump_done_q, dump_done_d;
  logic              snap_take;
  logic [XLEN-1:0]   snap_q [0:NUM_REGS-1];
  logic [SNAP_AW-1:0] rd_addr;

  // Word k (k >= 1) of the stream lives in snap_q[k-1]; while offering word
  // index_q the next word to load is snap_q[index_q].
  assign rd_addr = index_q[SNAP_AW-1:0];

  // Next-state and registered-output computation for the RUN/DUMP/DONE controller.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    cycle_count_d = cycle_count_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    timed_out_d   = timed_out_q;
    dump_done_d   = dump_done_q;
    snap_take     = 1'b0;
    unique case (state_q)
      RUN: begin
        // Halt beats timeout when both happen on the same cycle.
        if (completed || (cycle_count_q == TIMEOUT_AT)) begin
          snap_take   = 1'b1;
          state_d     = DUMP;
          index_d     = 6'd0;
          out_valid_d = 1'b1;
          out_data_d  = XLEN'(cycle_count_q);
          out_last_d  = (LAST_IDX == 6'd0);
          timed_out_d = !completed;
        end else begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
      end
      DUMP: begin
        if (out_ready) begin
          if (index_q == LAST_IDX) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            dump_done_d = 1'b1;
          end else begin
            index_d    = index_q + 6'd1;
            out_data_d = snap_q[rd_addr];
            out_last_d = ((index_q + 6'd1) == LAST_IDX);
          end
        end
      end
      DONE: begin
        // Parked until reset; completed is ignored here.
      end
      default: state_d = RUN;
    endcase
  end

  // Controller state and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      index_q       <= 6'd0;
      cycle_count_q <= 32'd0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      timed_out_q   <= 1'b0;
      dump_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      cycle_count_q <= cycle_count_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      timed_out_q   <= timed_out_d;
      dump_done_q   <= dump_done_d;
    end
  end

  // Capture the whole register file on the trigger cycle; later changes to
  // the live registers never reach the stream.
  always_ff @(posedge clk) begin
    if (snap_take && !rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        snap_q[i] <= registers[i];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_index   = index_q;
  assign out_last    = out_last_q;
  assign cycle_count = cycle_count_q;
  assign timed_out   = timed_out_q;
  assign dump_done   = dump_done_q;

endmodule
